booth_sequencer: RTL and testbench
==================================

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 Parameters: none; all widths are fixed (8x8 signed operands, 17-bit Booth register, 16-bit product).
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to begin a multiply; sampled on the rising edge.
REQ-005 Multiplicand  input  8  signed operand M; valid in the Start cycle.
REQ-006 Multiplier  input  8  signed operand Q; valid in the Start cycle.
REQ-007 AdderBoothResult  input  17  shifted result returned by the shared Booth adder.
REQ-008 AdderResultMsb  input  1  bit 16 of the shared adder's unshifted sum.
REQ-009 SelOperand  output  1  selects Booth operands on the shared adder.
REQ-010 Operation  output  1  1 = add BoothOperand then shift; 0 = shift BoothP only.
REQ-011 BoothOperand  output  17  addend for the adder.
REQ-012 BoothP  output  17  current Booth register P.
REQ-013 Busy  output  1  multiply in progress.
REQ-014 Done  output  1  one-cycle completion pulse.
REQ-015 ErrRange  output  1  set with Done when Multiplicand = -128.
REQ-016 Product  output  16  signed result; held until the next accepted Start.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; Busy = 1 only in RUN.
REQ-018 In IDLE or DONE, Start = 1 SHALL be accepted and all other Start cycles ignored. The state goes to RUN and the edge loads P = {8'h00, Multiplier, 1'b0}, count = 0, M register = Multiplicand.
REQ-019 If the accepted Multiplicand is 8'h80, the state SHALL go to DONE without entering RUN. That edge sets Product = 16'h0000 and ErrRange = 1.
REQ-020 In RUN, SelOperand SHALL be 1. Outside RUN, SelOperand = 0, Operation = 0 and BoothOperand = 0, so the adder is free for other users.
REQ-021 In RUN, Booth decode of P[1:0] SHALL be:
- 01: Operation = 1, BoothOperand = {M, 9'b0}.
- 10: Operation = 1, BoothOperand = {-M (8-bit two's complement), 9'b0}.
- 00 or 11: Operation = 0, BoothOperand = 0.
REQ-022 Each RUN edge SHALL load P <= {s, AdderBoothResult[15:0]} (arithmetic right shift) and increment count. The sign bit s is AdderResultMsb when Operation = 1, otherwise BoothP[16].
REQ-023 Upper-field arithmetic SHALL be modulo 2^17; the adder carry-out is discarded.
REQ-024 On the edge completing the 8th RUN update, the state SHALL go to DONE and Product SHALL load the new P[16:1].
REQ-025 Done SHALL be 1 for exactly the one cycle in DONE. Latency is 8 edges from the accepting edge to Product valid, and Done is asserted in the following cycle.
REQ-026 DONE SHALL return to IDLE on the next edge unless Start = 1, in which case a new multiply is accepted with no idle gap.
REQ-027 ErrRange SHALL clear on the next accepted Start and SHALL remain 0 for in-range operands.
REQ-028 BoothP SHALL always reflect the P register; it is 0 in IDLE after reset.

Reset
REQ-029 Rst = 1 SHALL immediately force IDLE, with P, M, count, Product, Busy, Done and ErrRange all 0, including mid-RUN.
REQ-030 After Rst deasserts, the first Start SHALL be accepted normally; no partial result from an aborted multiply appears on Product or Done.

Verification
REQ-031 M = 3, Q = 5, Start pulse -> Busy for 8 cycles, Done pulse, Product = 16'h000F, ErrRange = 0.
REQ-032 M = -3, Q = 5 -> Product = 16'hFFF1. M = 127, Q = -128 -> Product = 16'hC080. M = 0, Q = -1 -> Product = 16'h0000.
REQ-033 M = -128, Q = 7 -> no RUN cycles; Done pulse the cycle after acceptance with ErrRange = 1 and Product = 16'h0000.
REQ-034 Rst asserted in the 4th RUN cycle -> outputs 0 asynchronously, Done never pulses. A subsequent 2 x 2 yields 16'h0004.
REQ-035 Start held high during Done of 3 x 5, with new operands -7 x 6 -> second Busy begins immediately, Product becomes 16'hFFD6 8 edges later. Start pulses during Busy are ignored.
REQ-036 Bench SHALL check SelOperand = 1 only while Busy, and check that Operation and BoothOperand match the P[1:0] decode every RUN cycle.

Source files
------------

// File: rtl/booth_sequencer_if.sv
// Bus between the Booth sequencer and its user, including the shared-adder
// return path. The DUT side is the slave modport.
interface booth_sequencer_if;
  // Handshake: Start is sampled on a rising edge and accepted only while Busy
  // is low; an accepted multiply keeps Busy high for 8 cycles, then Done pulses
  // for one cycle with Product/ErrRange valid (held until the next accept).
  logic        Start;
  logic [7:0]  Multiplicand;
  logic [7:0]  Multiplier;
  logic [16:0] AdderBoothResult;
  logic        AdderResultMsb;
  logic        SelOperand;
  logic        Operation;
  logic [16:0] BoothOperand;
  logic [16:0] BoothP;
  logic        Busy;
  logic        Done;
  logic        ErrRange;
  logic [15:0] Product;
  logic [1:0]  DbgState;

  modport slave (
    input  Start, Multiplicand, Multiplier, AdderBoothResult, AdderResultMsb,
    output SelOperand, Operation, BoothOperand, BoothP, Busy, Done, ErrRange,
           Product, DbgState
  );

  modport master (
    output Start, Multiplicand, Multiplier, AdderBoothResult, AdderResultMsb,
    input  SelOperand, Operation, BoothOperand, BoothP, Busy, Done, ErrRange,
           Product, DbgState
  );
endinterface

// File: rtl/booth_sequencer.sv
// Radix-2 Booth sequencer for 8x8 signed multiplies; the add/shift itself is
// done by an external shared adder driven through SelOperand/Operation.
module booth_sequencer (
  input  logic                Clk,
  input  logic                Rst,
  booth_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [16:0] pReg;
  logic [7:0]  mReg;
  logic [2:0]  count;
  logic [15:0] productReg;
  logic        errReg;

  logic        accept;
  logic        rangeErr;
  logic [7:0]  mNeg;
  logic        operation;
  logic [16:0] boothOperand;
  logic        signBit;
  logic [16:0] pNext;
  logic        unusedAdderBit;

  assign accept         = bus.Start && (state != RUN);
  assign rangeErr       = (bus.Multiplicand == 8'h80);
  assign mNeg           = ~mReg + 8'd1;
  assign unusedAdderBit = bus.AdderBoothResult[16];

  // Sign comes from the adder only when it actually added something.
  assign signBit = operation ? bus.AdderResultMsb : pReg[16];
  assign pNext   = {signBit, bus.AdderBoothResult[15:0]};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    operation    = 1'b0;
    boothOperand = 17'd0;
    case (state)
      IDLE, DONE: begin
        if (bus.Start) begin
          stateNext = rangeErr ? DONE : RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        case (pReg[1:0])
          2'b01: begin
            operation    = 1'b1;
            boothOperand = {mReg, 9'd0};
          end
          2'b10: begin
            operation    = 1'b1;
            boothOperand = {mNeg, 9'd0};
          end
          default: begin
            operation    = 1'b0;
            boothOperand = 17'd0;
          end
        endcase
        if (count == 3'd7) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pReg       <= 17'd0;
      mReg       <= 8'd0;
      count      <= 3'd0;
      productReg <= 16'd0;
      errReg     <= 1'b0;
    end else if (accept) begin
      pReg   <= {8'h00, bus.Multiplier, 1'b0};
      mReg   <= bus.Multiplicand;
      count  <= 3'd0;
      errReg <= rangeErr;
      if (rangeErr) begin
        productReg <= 16'd0;
      end
    end else if (state == RUN) begin
      pReg  <= pNext;
      count <= count + 3'd1;
      if (count == 3'd7) begin
        productReg <= pNext[16:1];
      end
    end
  end

  assign bus.SelOperand   = (state == RUN);
  assign bus.Operation    = operation;
  assign bus.BoothOperand = boothOperand;
  assign bus.BoothP       = pReg;
  assign bus.Busy         = (state == RUN);
  assign bus.Done         = (state == DONE);
  assign bus.ErrRange     = errReg;
  assign bus.Product      = productReg;
  assign bus.DbgState     = state;

endmodule

// File: tb/tb_booth_sequencer.sv
// Scoreboard bench for booth_sequencer: drives multiplies, models the shared
// adder, and checks results and per-cycle Booth decode against plain arithmetic.
module tb_booth_sequencer;

  logic Clk;
  logic Rst;
  booth_sequencer_if bif ();

  booth_sequencer dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bif)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // shared adder model: 17-bit sum, then arithmetic shift right by one
  logic [16:0] add_sum;
  assign add_sum              = bif.BoothP + (bif.Operation ? bif.BoothOperand : 17'd0);
  assign bif.AdderBoothResult = {add_sum[16], add_sum[16:1]};
  assign bif.AdderResultMsb   = add_sum[16];

  // scoreboard
  logic [16:0]       exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  logic signed [7:0] cur_m = 8'sd0;
  int                busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_result(input logic signed [7:0] m, input logic signed [7:0] q);
    logic signed [15:0] p;
    if (m == -8'sd128) return {1'b1, 16'h0000};
    p = m * q;
    return {1'b0, p};
  endfunction

  // monitor
  always @(negedge Clk) begin
    logic [16:0] e;
    logic        exp_op;
    logic [16:0] exp_opnd;
    logic [7:0]  neg_m;
    if (Rst) begin
      busy_len = 0;
    end else begin
      check("sel_vs_busy", {31'd0, bif.SelOperand}, {31'd0, bif.Busy});
      if (bif.Busy) begin
        busy_len++;
        neg_m = 8'(-cur_m);
        exp_op   = (bif.BoothP[1:0] == 2'b01) || (bif.BoothP[1:0] == 2'b10);
        exp_opnd = (bif.BoothP[1:0] == 2'b01) ? {cur_m, 9'd0} :
                   (bif.BoothP[1:0] == 2'b10) ? {neg_m, 9'd0} : 17'd0;
        check("run_operation", {31'd0, bif.Operation}, {31'd0, exp_op});
        check("run_operand", {15'd0, bif.BoothOperand}, {15'd0, exp_opnd});
      end else begin
        check("idle_operation", {31'd0, bif.Operation}, 32'd0);
        check("idle_operand", {15'd0, bif.BoothOperand}, 32'd0);
      end
      if (bif.Done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: actual=Done required=no_done time=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("product", {16'd0, bif.Product}, {16'd0, e[15:0]});
          check("err_range", {31'd0, bif.ErrRange}, {31'd0, e[16]});
          check("busy_cycles", busy_len, e[16] ? 32'd0 : 32'd8);
        end
        busy_len = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge Clk);
    while (bif.Busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: actual=busy required=idle time=%0t", $time);
    end
  endtask

  task automatic drive_start(input logic [7:0] m, input logic [7:0] q);
    bif.Start        = 1'b1;
    bif.Multiplicand = m;
    bif.Multiplier   = q;
    cur_m            = m;
    exp_q.push_back(ref_result(m, q));
    @(posedge Clk);
    #1;
    bif.Start = 1'b0;
  endtask

  task automatic issue(input logic [7:0] m, input logic [7:0] q);
    wait_ready();
    drive_start(m, q);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge Clk);
    while (!bif.Done && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: actual=no_done required=Done time=%0t", $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_boothp"}, {15'd0, bif.BoothP}, 32'd0);
    check({tag, "_busy"}, {31'd0, bif.Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bif.Done}, 32'd0);
    check({tag, "_product"}, {16'd0, bif.Product}, 32'd0);
    check({tag, "_errrange"}, {31'd0, bif.ErrRange}, 32'd0);
    check({tag, "_sel"}, {31'd0, bif.SelOperand}, 32'd0);
  endtask

  // stimulus
  initial begin
    logic [7:0] rm;
    logic [7:0] rq;
    Rst              = 1'b1;
    bif.Start        = 1'b0;
    bif.Multiplicand = 8'd0;
    bif.Multiplier   = 8'd0;
    #23;
    check_all_zero("reset");
    @(negedge Clk);
    Rst = 1'b0;

    issue(8'd3, 8'd5);
    issue(8'hFD, 8'd5);
    issue(8'd127, 8'h80);
    issue(8'd0, 8'hFF);
    issue(8'h80, 8'd7);

    // back-to-back start during Done, then a Start pulse while Busy
    issue(8'd3, 8'd5);
    wait_done();
    drive_start(8'hF9, 8'd6);
    @(negedge Clk);
    @(negedge Clk);
    bif.Start        = 1'b1;
    bif.Multiplicand = 8'd55;
    bif.Multiplier   = 8'd99;
    @(negedge Clk);
    bif.Start = 1'b0;

    // abort in the 4th RUN cycle
    issue(8'd3, 8'd5);
    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    issue(8'd2, 8'd2);

    for (int i = 0; i < 40; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      case ($urandom_range(0, 9))
        0: rm = 8'h80;
        1: rq = 8'h80;
        2: rm = 8'h7F;
        3: rq = 8'h00;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      issue(rm, rq);
    end

    wait_ready();
    repeat (4) @(negedge Clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
